// File: rtl/byte_packer.sv
// byte_packer: packs variable-length compressed beats into full OUT_BYTES-wide
// output beats, and passes raw (uncompressed/header) beats through unpacked.
// Optional feature macro: BYTE_PACKER_BYTECNT_EN adds a 32-bit byte_count_o
// output that accumulates delivered bytes per stream.
module byte_packer #(
    parameter int OUT_BYTES     = 32,
    parameter int TAG_WIDTH     = 16,
    parameter int LEN_WIDTH     = 8,
    parameter int DATA_IN_WIDTH = OUT_BYTES*8 + TAG_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid_i,
    output logic                     s_ready_o,
    input  logic [DATA_IN_WIDTH-1:0] s_data_i,
    input  logic [LEN_WIDTH-1:0]     s_len_i,
    input  logic                     s_raw_i,
    input  logic                     s_last_i,
    output logic                     m_valid_o,
    input  logic                     m_ready_i,
    output logic [OUT_BYTES*8-1:0]   m_data_o,
    output logic [OUT_BYTES-1:0]     m_keep_o,
    output logic                     m_last_o
`ifdef BYTE_PACKER_BYTECNT_EN
    ,
    output logic [31:0]              byte_count_o
`endif
);

    localparam int DW = OUT_BYTES*8;
    localparam int BW = 2*DW;
    localparam int FW = $clog2(2*OUT_BYTES+1);
    localparam logic [FW-1:0] OB_F = FW'(OUT_BYTES);

    typedef enum logic [1:0] {ST_RUN, ST_FLUSH, ST_RAW} state_t;

    state_t                 state_q, state_d;
    logic [BW-1:0]          buf_q, buf_d;
    logic [FW-1:0]          fill_q, fill_d;
    logic [DW-1:0]          raw_q, raw_d;
    logic                   raw_last_q, raw_last_d;
    logic                   s_ready_q, s_ready_d;
    logic                   m_valid_q, m_valid_d;
    logic [DW-1:0]          m_data_q, m_data_d;
    logic [OUT_BYTES-1:0]   m_keep_q, m_keep_d;
    logic                   m_last_q, m_last_d;

    logic                   out_free;
    logic                   accept;
    logic [FW-1:0]          len_eff;
    logic [OUT_BYTES-1:0]   len_keep;
    logic [DW-1:0]          len_bits;
    logic [DW-1:0]          in_masked;
    logic [BW-1:0]          buf_base;
    logic [FW-1:0]          fill_base;

    // Mask with the low n bits set, n in 0..OUT_BYTES.
    function automatic logic [OUT_BYTES-1:0] low_mask(input logic [FW-1:0] n);
        logic [OUT_BYTES-1:0] m;
        for (int i = 0; i < OUT_BYTES; i++) begin
            m[i] = (FW'(i) < n);
        end
        return m;
    endfunction

    assign out_free = !m_valid_q || m_ready_i;
    assign accept   = s_valid_i && s_ready_q;

    // Clamp the payload length so an out-of-range s_len cannot overrun the buffer.
    always_comb begin
        if (s_len_i > LEN_WIDTH'(OUT_BYTES)) begin
            len_eff = OB_F;
        end else begin
            len_eff = FW'(s_len_i);
        end
    end

    assign len_keep = low_mask(len_eff);

    // Zero payload bytes past s_len so the buffer above fill always stays zero.
    for (genvar gi = 0; gi < OUT_BYTES; gi++) begin : g_len_mask
        assign len_bits[gi*8 +: 8] = {8{len_keep[gi]}};
    end
    assign in_masked = s_data_i[DW-1:0] & len_bits;

    // Next-state logic: buffer append/drain, flush and raw pass-through sequencing.
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        fill_d     = fill_q;
        raw_d      = raw_q;
        raw_last_d = raw_last_q;
        buf_base   = buf_q;
        fill_base  = fill_q;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        m_keep_d   = m_keep_q;
        m_last_d   = m_last_q;
        if (out_free) begin
            m_valid_d = 1'b0;
            m_data_d  = '0;
            m_keep_d  = '0;
            m_last_d  = 1'b0;
        end
        case (state_q)
            ST_RUN: begin
                if (out_free && (fill_q >= OB_F)) begin
                    m_valid_d = 1'b1;
                    m_data_d  = buf_q[DW-1:0];
                    m_keep_d  = '1;
                    m_last_d  = 1'b0;
                    buf_base  = buf_q >> DW;
                    fill_base = fill_q - OB_F;
                end
                buf_d  = buf_base;
                fill_d = fill_base;
                if (accept) begin
                    if (s_raw_i) begin
                        raw_d      = s_data_i[TAG_WIDTH +: DW];
                        raw_last_d = s_last_i;
                        state_d    = ST_RAW;
                    end else begin
                        // New bytes land at the post-drain offset.
                        buf_d  = buf_base | ({{DW{1'b0}}, in_masked} << {fill_base, 3'b000});
                        fill_d = fill_base + len_eff;
                        if (s_last_i) begin
                            state_d = ST_FLUSH;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                if (out_free) begin
                    m_valid_d = 1'b1;
                    m_data_d  = buf_q[DW-1:0];
                    if (fill_q > OB_F) begin
                        m_keep_d = '1;
                        m_last_d = 1'b0;
                        buf_d    = buf_q >> DW;
                        fill_d   = fill_q - OB_F;
                    end else begin
                        // Tail beat; an empty buffer still yields a keep=0 last beat.
                        m_keep_d = low_mask(fill_q);
                        m_last_d = 1'b1;
                        buf_d    = '0;
                        fill_d   = '0;
                        state_d  = ST_RUN;
                    end
                end
            end
            ST_RAW: begin
                if (out_free) begin
                    m_valid_d = 1'b1;
                    if (fill_q != '0) begin
                        // Pending packed bytes go out first so ordering is preserved.
                        m_data_d = buf_q[DW-1:0];
                        m_keep_d = low_mask(fill_q);
                        m_last_d = 1'b0;
                        buf_d    = '0;
                        fill_d   = '0;
                    end else begin
                        m_data_d   = raw_q;
                        m_keep_d   = '1;
                        m_last_d   = raw_last_q;
                        raw_d      = '0;
                        raw_last_d = 1'b0;
                        state_d    = ST_RUN;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        s_ready_d = (state_d == ST_RUN) && (fill_d <= OB_F);
    end

    // State and registered outputs; reset clears everything including s_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            buf_q      <= '0;
            fill_q     <= '0;
            raw_q      <= '0;
            raw_last_q <= 1'b0;
            s_ready_q  <= 1'b0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            m_keep_q   <= '0;
            m_last_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            fill_q     <= fill_d;
            raw_q      <= raw_d;
            raw_last_q <= raw_last_d;
            s_ready_q  <= s_ready_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            m_keep_q   <= m_keep_d;
            m_last_q   <= m_last_d;
        end
    end

    assign s_ready_o = s_ready_q;
    assign m_valid_o = m_valid_q;
    assign m_data_o  = m_data_q;
    assign m_keep_o  = m_keep_q;
    assign m_last_o  = m_last_q;

`ifdef BYTE_PACKER_BYTECNT_EN
    logic [31:0] byte_count_q, byte_count_d;
    logic        cnt_clr_q, cnt_clr_d;
    logic        m_fire;

    assign m_fire = m_valid_q && m_ready_i;

    // Accumulate delivered bytes; the total stays visible one cycle after m_last.
    always_comb begin
        byte_count_d = cnt_clr_q ? 32'd0 : byte_count_q;
        cnt_clr_d    = 1'b0;
        if (m_fire) begin
            byte_count_d = byte_count_d + 32'($countones(m_keep_q));
            cnt_clr_d    = m_last_q;
        end
    end

    // Byte counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_count_q <= '0;
            cnt_clr_q    <= 1'b0;
        end else begin
            byte_count_q <= byte_count_d;
            cnt_clr_q    <= cnt_clr_d;
        end
    end

    assign byte_count_o = byte_count_q;
`endif

endmodule

// File: tb/tb_byte_packer.sv
// Directed testbench for byte_packer (OUT_BYTES=32, TAG_WIDTH=16, LEN_WIDTH=8).
// Byte-count checks are compiled in when BYTE_PACKER_BYTECNT_EN is defined.
module tb_byte_packer;

    logic         clk;
    logic         rst_n;
    logic         s_valid_i;
    logic         s_ready_o;
    logic [271:0] s_data_i;
    logic [7:0]   s_len_i;
    logic         s_raw_i;
    logic         s_last_i;
    logic         m_valid_o;
    logic         m_ready_i;
    logic [255:0] m_data_o;
    logic [31:0]  m_keep_o;
    logic         m_last_o;
`ifdef BYTE_PACKER_BYTECNT_EN
    logic [31:0]  byte_count_o;
`endif

    byte_packer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_valid_i (s_valid_i),
        .s_ready_o (s_ready_o),
        .s_data_i  (s_data_i),
        .s_len_i   (s_len_i),
        .s_raw_i   (s_raw_i),
        .s_last_i  (s_last_i),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i),
        .m_data_o  (m_data_o),
        .m_keep_o  (m_keep_o),
        .m_last_o  (m_last_o)
`ifdef BYTE_PACKER_BYTECNT_EN
        ,
        .byte_count_o (byte_count_o)
`endif
    );

    int n_vec  = 0;
    int n_miss = 0;

    logic [255:0] q_data[$];
    logic [31:0]  q_keep[$];
    logic         q_last[$];
    logic [255:0] e_data[$];
    logic [31:0]  e_keep[$];
    logic         e_last[$];

    logic         toggle_ready = 1'b0;
    logic         t4_active    = 1'b0;
    logic         saw_not_ready = 1'b0;
    logic         stall_prev   = 1'b0;
    logic [288:0] held         = '0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] ramp(input int start, input int n);
        logic [255:0] r = '0;
        for (int j = 0; j < n; j++) r[j*8 +: 8] = 8'(start + j);
        return r;
    endfunction

    function automatic logic [255:0] junk(input int n);
        logic [255:0] r = '0;
        for (int j = n; j < 32; j++) r[j*8 +: 8] = 8'hEE;
        return r;
    endfunction

    function automatic logic [271:0] comp_beat(input int start, input int n);
        return {16'h5A5A, ramp(start, n) | junk(n)};
    endfunction

    // Output monitor: records handshakes and checks stability while stalled.
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_prev) chk("hold", {m_data_o, m_keep_o, m_last_o}, {31'd0, held});
            stall_prev = m_valid_o && !m_ready_i;
            held = {m_data_o, m_keep_o, m_last_o};
            if (m_valid_o && m_ready_i) begin
                q_data.push_back(m_data_o);
                q_keep.push_back(m_keep_o);
                q_last.push_back(m_last_o);
                $display("beat: keep=%08h last=%0d data=%064h", m_keep_o, m_last_o, m_data_o);
            end
            if (t4_active && !s_ready_o) saw_not_ready = 1'b1;
        end else begin
            stall_prev = 1'b0;
        end
    end

    // m_ready driver: toggles each cycle when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (toggle_ready) m_ready_i = ~m_ready_i;
        end
    end

    // Present one input beat and hold it until accepted (called at posedge+1).
    task automatic send(input int len, input logic [271:0] data, input logic raw, input logic last);
        int  n = 0;
        bit  done = 0;
        logic rdy;
        s_valid_i = 1'b1;
        s_len_i   = 8'(len);
        s_data_i  = data;
        s_raw_i   = raw;
        s_last_i  = last;
        while (!done && n < 200) begin
            @(negedge clk);
            rdy = s_ready_o;
            @(posedge clk);
            #1;
            n++;
            if (rdy) done = 1;
        end
        if (!done) chk("send_timeout", 320'(n), 320'(0));
        $display("in: len=%0d raw=%0d last=%0d", len, raw, last);
        s_valid_i = 1'b0;
        s_raw_i   = 1'b0;
        s_last_i  = 1'b0;
    endtask

    task automatic expect_beat(input logic [255:0] d, input logic [31:0] k, input logic l);
        e_data.push_back(d);
        e_keep.push_back(k);
        e_last.push_back(l);
    endtask

    task automatic clear_q();
        q_data.delete(); q_keep.delete(); q_last.delete();
    endtask

    // Wait for the expected beats (bounded), then compare everything collected.
    task automatic verify(input string tag);
        int c = 0;
        int n;
        while (q_data.size() < e_data.size() && c < 400) begin
            @(posedge clk);
            #1;
            c++;
        end
        repeat (6) @(posedge clk);
        #1;
        chk({tag, "_count"}, 320'(q_data.size()), 320'(e_data.size()));
        n = (q_data.size() < e_data.size()) ? q_data.size() : e_data.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_data%0d", tag, i), 320'(q_data[i]), 320'(e_data[i]));
            chk($sformatf("%s_keep%0d", tag, i), 320'(q_keep[i]), 320'(e_keep[i]));
            chk($sformatf("%s_last%0d", tag, i), 320'(q_last[i]), 320'(e_last[i]));
        end
        e_data.delete(); e_keep.delete(); e_last.delete();
        clear_q();
    endtask

    initial begin
        rst_n     = 1'b0;
        s_valid_i = 1'b0;
        s_data_i  = '0;
        s_len_i   = '0;
        s_raw_i   = 1'b0;
        s_last_i  = 1'b0;
        m_ready_i = 1'b1;

        // Reset state
        #3;
        chk("rst_m_valid", 320'(m_valid_o), 320'(0));
        chk("rst_m_data",  320'(m_data_o),  320'(0));
        chk("rst_m_keep",  320'(m_keep_o),  320'(0));
        chk("rst_m_last",  320'(m_last_o),  320'(0));
        chk("rst_s_ready", 320'(s_ready_o), 320'(0));
        #19 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_s_ready_rise", 320'(s_ready_o), 320'(1));

        // 20+20+24 bytes -> two full beats, last on the second
        send(20, comp_beat(0, 20), 1'b0, 1'b0);
        send(20, comp_beat(20, 20), 1'b0, 1'b0);
        send(24, comp_beat(40, 24), 1'b0, 1'b1);
        expect_beat(ramp(0, 32), 32'hFFFF_FFFF, 1'b0);
        expect_beat(ramp(32, 32), 32'hFFFF_FFFF, 1'b1);
        verify("t1");

        // 10 packed bytes then a raw beat: partial beat first, tag dropped
        send(10, comp_beat(8'h40, 10), 1'b0, 1'b0);
        send(0, {ramp(0, 32), 16'hABCD}, 1'b1, 1'b1);
        expect_beat(ramp(8'h40, 10), 32'h0000_03FF, 1'b0);
        expect_beat(ramp(0, 32), 32'hFFFF_FFFF, 1'b1);
        verify("t2");

        // Zero-length last beat on an empty buffer
        send(0, comp_beat(0, 0), 1'b0, 1'b1);
        expect_beat('0, 32'h0, 1'b1);
        verify("t3");

        // Full-width beats with m_ready toggling every cycle
        t4_active    = 1'b1;
        toggle_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) chk("t4_s_ready_dropped", 320'(saw_not_ready), 320'(1));
            send(32, comp_beat(32*i, 32), 1'b0, (i == 5));
            expect_beat(ramp(32*i, 32), 32'hFFFF_FFFF, (i == 5));
        end
        t4_active = 1'b0;
        verify("t4");
        toggle_ready = 1'b0;
        @(posedge clk);
        #1;
        m_ready_i = 1'b1;

        // Reset mid-stream with fill=17 and an output beat pending
        m_ready_i = 1'b0;
        send(32, comp_beat(8'h60, 32), 1'b0, 1'b0);
        send(17, comp_beat(8'h80, 17), 1'b0, 1'b0);
        chk("t5_pre_m_valid", 320'(m_valid_o), 320'(1));
        #1 rst_n = 1'b0;
        #1;
        chk("t5_m_valid", 320'(m_valid_o), 320'(0));
        chk("t5_m_data",  320'(m_data_o),  320'(0));
        chk("t5_m_keep",  320'(m_keep_o),  320'(0));
        chk("t5_m_last",  320'(m_last_o),  320'(0));
        chk("t5_s_ready", 320'(s_ready_o), 320'(0));
        @(posedge clk);
        #3 rst_n = 1'b1;
        m_ready_i = 1'b1;
        clear_q();
        repeat (10) @(posedge clk);
        #1;
        chk("t5_residual", 320'(q_data.size()), 320'(0));
        send(3, comp_beat(8'h90, 3), 1'b0, 1'b1);
        expect_beat(ramp(8'h90, 3), 32'h0000_0007, 1'b1);
        verify("t5");

`ifdef BYTE_PACKER_BYTECNT_EN
        // Byte counter: 5+7 bytes, total visible after m_last, then cleared
        begin
            int c = 0;
            send(5, comp_beat(8'hA0, 5), 1'b0, 1'b0);
            send(7, comp_beat(8'hA5, 7), 1'b0, 1'b1);
            while (q_data.size() < 1 && c < 100) begin
                @(posedge clk);
                #1;
                c++;
            end
            chk("bc_total", 320'(byte_count_o), 320'(12));
            @(posedge clk);
            #1;
            chk("bc_clear", 320'(byte_count_o), 320'(0));
            expect_beat(ramp(8'hA0, 12), 32'h0000_0FFF, 1'b1);
            verify("bc");
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
